alu_op_sequencer: RTL and testbench

Clocked front-end controller for the combinational 16-bit ALU (commands: 1 add, 2 sub, 3 mul, 4 div, 5 mod).
- Accepts operations over a valid/ready request channel and pre-screens illegal and divide-by-zero commands.
- Drives the ALU operand and command inputs, holds them for a fixed settle time, then registers result and error.
- Returns result and error over a valid/ready response channel.
- Keeps a 32-bit accumulator so operations can chain, plus a sticky error register and a completed-operation counter.

---
 rtl/alu_seq_pkg.sv | 26 ++
 rtl/alu_op_sequencer.sv | 131 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the ALU operation sequencer.
//   - ALU command codes (CMD_*)
//   - error bit positions and the illegal-command error code
//   - sequencer FSM state enum
//   - cmd_legal(): true for the commands the ALU implements
`timescale 1ns/1ps
package alu_seq_pkg;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_MUL = 4'd3;
  localparam logic [3:0] CMD_DIV = 4'd4;
  localparam logic [3:0] CMD_MOD = 4'd5;

  localparam int ERR_DBZ = 1;
  localparam int ERR_OVF = 0;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  function automatic logic cmd_legal(input logic [3:0] c);
    return (c >= CMD_ADD) && (c <= CMD_MOD);
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: clocked front end for a combinational ALU.
//   Request channel  : req_valid/req_ready, req_cmd, req_a, req_b, req_use_acc
//   Response channel : resp_valid/resp_ready, resp_result, resp_error
//   ALU interface    : alu_a, alu_b, alu_cmd out; alu_result, alu_error in
//   Status           : acc (chaining accumulator), sticky_err (+ clr_sticky),
//                      op_count (completed responses), busy
// Illegal commands and divide/modulo by zero are answered directly without
// touching the ALU; legal commands are held on the ALU for SETTLE_CYCLES
// before the result is captured.
`timescale 1ns/1ps
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int OPW           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_cmd,
  input  logic [OPW-1:0]   req_a,
  input  logic [OPW-1:0]   req_b,
  input  logic             req_use_acc,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [2*OPW-1:0] resp_result,
  output logic [1:0]       resp_error,
  output logic [OPW-1:0]   alu_a,
  output logic [OPW-1:0]   alu_b,
  output logic [3:0]       alu_cmd,
  input  logic [2*OPW-1:0] alu_result,
  input  logic [1:0]       alu_error,
  output logic [2*OPW-1:0] acc,
  output logic [1:0]       sticky_err,
  input  logic             clr_sticky,
  output logic [15:0]      op_count,
  output logic             busy
);

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
  localparam logic [1:0] DBZ_CODE = 2'(1 << ERR_DBZ);

  state_t         state;
  logic [3:0]     cnt;
  logic [OPW-1:0] a_sel;
  logic           is_divmod;
  logic           settle_ovf;
  logic           hs;
  // The ALU's own dbz flag is never consulted: B==0 is screened before issue.
  logic           unused_dbz;

  assign unused_dbz = alu_error[ERR_DBZ];
  assign a_sel      = req_use_acc ? acc[OPW-1:0] : req_a;
  assign is_divmod  = (req_cmd == CMD_DIV) || (req_cmd == CMD_MOD);
  // Overflow only has meaning for add/sub; mul/div/mod flags are dropped.
  assign settle_ovf = alu_error[ERR_OVF] && ((alu_cmd == CMD_ADD) || (alu_cmd == CMD_SUB));
  assign hs         = resp_valid && resp_ready;
  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_cmd     <= CMD_NOP;
      resp_valid  <= 1'b0;
      resp_result <= '0;
      resp_error  <= '0;
      acc         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (!cmd_legal(req_cmd)) begin
              resp_result <= '0;
              resp_error  <= ERR_ILLEGAL;
              resp_valid  <= 1'b1;
              state       <= RESP;
            end else if (is_divmod && (req_b == '0)) begin
              resp_result <= '0;
              resp_error  <= DBZ_CODE;
              resp_valid  <= 1'b1;
              state       <= RESP;
            end else begin
              alu_a   <= a_sel;
              alu_b   <= req_b;
              alu_cmd <= req_cmd;
              cnt     <= CNT_INIT;
              state   <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            resp_result <= alu_result;
            resp_error  <= {1'b0, settle_ovf};
            resp_valid  <= 1'b1;
            if (!settle_ovf) acc <= alu_result;
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            alu_cmd    <= CMD_NOP;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A handshake in the same cycle as clr_sticky leaves just the new error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_err <= '0;
      op_count   <= '0;
    end else begin
      if (hs) sticky_err <= clr_sticky ? resp_error : (sticky_err | resp_error);
      else if (clr_sticky) sticky_err <= '0;
      if (hs) op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: self-checking bench for alu_op_sequencer.
// A behavioural ALU answers the sequencer; a negedge monitor pushes expected
// responses on each accepted request and pops/compares them on each response
// handshake. Scenario tasks add latency, stability and status checks.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int S = 2;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_cmd = '0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic        req_use_acc = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_result;
  logic [1:0]  resp_error;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_cmd;
  logic [31:0] alu_result;
  logic [1:0]  alu_error;
  logic [31:0] acc;
  logic [1:0]  sticky_err;
  logic        clr_sticky = 1'b0;
  logic [15:0] op_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] m_acc = '0;
  logic [1:0]  m_sticky = '0;
  logic [15:0] m_cnt = '0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.SETTLE_CYCLES(S), .OPW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_a(req_a), .req_b(req_b), .req_use_acc(req_use_acc),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_error(resp_error),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
    .alu_result(alu_result), .alu_error(alu_error),
    .acc(acc), .sticky_err(sticky_err), .clr_sticky(clr_sticky),
    .op_count(op_count), .busy(busy)
  );

  // Behavioural ALU. Mul raises its overflow flag on a >16-bit product and
  // div/mod by zero raise dbz, so the sequencer's masking is exercised.
  logic [15:0] alu_sum, alu_dif;
  logic [31:0] alu_prod;
  assign alu_sum  = alu_a + alu_b;
  assign alu_dif  = alu_a - alu_b;
  assign alu_prod = 32'(alu_a) * 32'(alu_b);

  always_comb begin
    alu_result = '0;
    alu_error  = '0;
    case (alu_cmd)
      CMD_ADD: begin
        alu_result   = {16'h0, alu_sum};
        alu_error[0] = (alu_a[15] == alu_b[15]) && (alu_sum[15] != alu_a[15]);
      end
      CMD_SUB: begin
        alu_result   = {16'h0, alu_dif};
        alu_error[0] = (alu_a[15] != alu_b[15]) && (alu_dif[15] != alu_a[15]);
      end
      CMD_MUL: begin
        alu_result   = alu_prod;
        alu_error[0] = |alu_prod[31:16];
      end
      CMD_DIV: begin
        if (alu_b == '0) begin alu_result = '1; alu_error[1] = 1'b1; end
        else alu_result = {16'h0, alu_a / alu_b};
      end
      CMD_MOD: begin
        if (alu_b == '0) begin alu_result = '1; alu_error[1] = 1'b1; end
        else alu_result = {16'h0, alu_a % alu_b};
      end
      default: ;
    endcase
  end

  // Expected response, computed with signed integer range checks.
  function automatic exp_t model(input logic [3:0] cmd, input logic [15:0] a, input logic [15:0] b);
    exp_t r;
    int sa, sbv, s;
    r.res = '0;
    r.err = 2'b00;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    case (cmd)
      4'd1: begin s = sa + sbv; r.res = {16'h0, a + b}; r.err[0] = (s > 32767) || (s < -32768); end
      4'd2: begin s = sa - sbv; r.res = {16'h0, a - b}; r.err[0] = (s > 32767) || (s < -32768); end
      4'd3: r.res = 32'(a) * 32'(b);
      4'd4: if (b == '0) r.err = 2'b10; else r.res = 32'(a / b);
      4'd5: if (b == '0) r.err = 2'b10; else r.res = 32'(a % b);
      default: r.err = 2'b11;
    endcase
    return r;
  endfunction

  // Scoreboard monitor: inputs change at posedge+1, so negedge sees them stable.
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid && resp_ready) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: response result=%h err=%b with nothing outstanding", resp_result, resp_error);
        end else begin
          mon_e = sbq.pop_front();
          if (resp_result !== mon_e.res || resp_error !== mon_e.err) begin
            errors++;
            $display("FAIL sb_resp: got result=%h err=%b expected result=%h err=%b",
                     resp_result, resp_error, mon_e.res, mon_e.err);
          end
          if (mon_e.err == 2'b00) m_acc = mon_e.res;
          checks++;
          if (acc !== m_acc) begin
            errors++;
            $display("FAIL sb_acc: got %h expected %h", acc, m_acc);
          end
          m_cnt++;
          m_sticky = clr_sticky ? mon_e.err : (m_sticky | mon_e.err);
        end
      end else if (clr_sticky) begin
        m_sticky = 2'b00;
      end
      if (req_valid && req_ready)
        sbq.push_back(model(req_cmd, req_use_acc ? m_acc[15:0] : req_a, req_b));
    end
  end

  // One operation with resp_ready high; exp_lat counts edges from the accept
  // edge through the edge that raises resp_valid.
  task automatic run_op(input logic [3:0] cmd, input logic [15:0] a, input logic [15:0] b,
                        input logic ua, input int exp_lat);
    int lat;
    logic [15:0] exp_a;
    exp_a = ua ? m_acc[15:0] : a;
    req_cmd = cmd; req_a = a; req_b = b; req_use_acc = ua;
    resp_ready = 1'b1; req_valid = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL op_ready: req_ready=%b expected 1 before cmd %0d", req_ready, cmd);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    if (exp_lat > 1) begin
      checks++;
      if (alu_a !== exp_a || alu_b !== b || alu_cmd !== cmd) begin
        errors++;
        $display("FAIL op_issue: alu a=%h b=%h cmd=%0d expected a=%h b=%h cmd=%0d",
                 alu_a, alu_b, alu_cmd, exp_a, b, cmd);
      end
    end
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL op_latency: cmd %0d took %0d cycles expected %0d", cmd, lat, exp_lat);
    end
    if (exp_lat == 1) begin
      checks++;
      if (alu_cmd !== CMD_NOP) begin
        errors++;
        $display("FAIL op_screen_alu: alu_cmd=%0d expected 0", alu_cmd);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0 || alu_cmd !== CMD_NOP) begin
      errors++;
      $display("FAIL op_idle: busy=%b req_ready=%b resp_valid=%b alu_cmd=%0d expected 0 1 0 0",
               busy, req_ready, resp_valid, alu_cmd);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_result !== '0 || resp_error !== '0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_resp: valid=%b result=%h err=%b busy=%b ready=%b expected 0 0 0 0 1",
               resp_valid, resp_result, resp_error, busy, req_ready);
    end
    checks++;
    if (alu_a !== '0 || alu_b !== '0 || alu_cmd !== '0 || acc !== '0 || sticky_err !== '0 || op_count !== '0) begin
      errors++;
      $display("FAIL reset_state: alu_a=%h alu_b=%h alu_cmd=%h acc=%h sticky=%b count=%0d expected all 0",
               alu_a, alu_b, alu_cmd, acc, sticky_err, op_count);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_cmds;
    logic [31:0] tbl [5];
    tbl = '{32'd318, 32'd180, 32'd17181, 32'd3, 32'd42};
    for (int i = 0; i < 5; i++) begin
      run_op(4'(i + 1), 16'd249, 16'd69, 1'b0, S + 1);
      checks++;
      if (acc !== tbl[i]) begin
        errors++;
        $display("FAIL cmds_acc: cmd %0d acc=%0d expected %0d", i + 1, acc, tbl[i]);
      end
    end
    checks++;
    if (op_count !== 16'd5 || sticky_err !== 2'b00) begin
      errors++;
      $display("FAIL cmds_status: op_count=%0d sticky=%b expected 5 00", op_count, sticky_err);
    end
  endtask

  task automatic test_overflow;
    run_op(CMD_ADD, 16'd32000, 16'd8193, 1'b0, S + 1);
    checks++;
    if (acc !== 32'd42 || sticky_err !== 2'b01) begin
      errors++;
      $display("FAIL ovf_status: acc=%0d sticky=%b expected 42 01", acc, sticky_err);
    end
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    checks++;
    if (sticky_err !== 2'b00) begin
      errors++;
      $display("FAIL ovf_clear: sticky=%b expected 00", sticky_err);
    end
    // Large product: ALU flags overflow, sequencer must ignore it for mul.
    run_op(CMD_MUL, 16'd1000, 16'd1000, 1'b0, S + 1);
    checks++;
    if (acc !== 32'd1000000 || sticky_err !== 2'b00) begin
      errors++;
      $display("FAIL mul_mask: acc=%0d sticky=%b expected 1000000 00", acc, sticky_err);
    end
  endtask

  task automatic test_screen;
    run_op(CMD_DIV, 16'd5, 16'd0, 1'b0, 1);
    run_op(CMD_MOD, 16'd5, 16'd0, 1'b0, 1);
    checks++;
    if (sticky_err !== 2'b10) begin
      errors++;
      $display("FAIL screen_dbz_sticky: sticky=%b expected 10", sticky_err);
    end
    run_op(4'd7, 16'd5, 16'd3, 1'b0, 1);
    run_op(4'd0, 16'd5, 16'd3, 1'b0, 1);
    run_op(4'd6, 16'd5, 16'd3, 1'b0, 1);
    checks++;
    if (sticky_err !== 2'b11 || op_count !== m_cnt || acc !== 32'd1000000) begin
      errors++;
      $display("FAIL screen_status: sticky=%b count=%0d acc=%0d expected 11 %0d 1000000",
               sticky_err, op_count, acc, m_cnt);
    end
  endtask

  task automatic test_set_wins;
    clr_sticky = 1'b1;
    run_op(CMD_DIV, 16'd9, 16'd0, 1'b0, 1);
    clr_sticky = 1'b0;
    checks++;
    if (sticky_err !== 2'b10 || sticky_err !== m_sticky) begin
      errors++;
      $display("FAIL set_wins: sticky=%b expected 10", sticky_err);
    end
  endtask

  task automatic test_chain;
    run_op(CMD_ADD, 16'd249, 16'd69, 1'b0, S + 1);
    checks++;
    if (acc !== 32'd318) begin
      errors++;
      $display("FAIL chain_first: acc=%0d expected 318", acc);
    end
    run_op(CMD_MUL, 16'hFFFF, 16'd2, 1'b1, S + 1);
    checks++;
    if (acc !== 32'd636) begin
      errors++;
      $display("FAIL chain_acc: acc=%0d expected 636", acc);
    end
  endtask

  task automatic test_back_to_back;
    int t[3];
    int n, k;
    n = 0; k = 0;
    req_cmd = CMD_SUB; req_a = 16'd50; req_b = 16'd8; req_use_acc = 1'b0;
    resp_ready = 1'b1; req_valid = 1'b1;
    while (k < 3 && n < 40) begin
      if (req_ready) begin t[k] = n; k++; end
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    checks++;
    if (k != 3 || (t[1] - t[0]) != S + 2 || (t[2] - t[1]) != S + 2) begin
      errors++;
      $display("FAIL b2b_interval: accepts=%0d gaps %0d %0d expected 3 accepts gaps %0d",
               k, t[1] - t[0], t[2] - t[1], S + 2);
    end
    n = 0;
    while (busy && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (busy !== 1'b0 || sbq.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: busy=%b outstanding=%0d expected 0 0", busy, sbq.size());
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] hold;
    int n;
    resp_ready = 1'b0;
    req_cmd = CMD_MUL; req_a = 16'd300; req_b = 16'd7; req_use_acc = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    // Second request stays asserted while the first is stalled.
    req_cmd = CMD_ADD; req_a = 16'd1; req_b = 16'd1;
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    hold = resp_result;
    checks++;
    if (resp_valid !== 1'b1 || hold !== 32'd2100) begin
      errors++;
      $display("FAIL bp_resp: valid=%b result=%0d expected 1 2100", resp_valid, hold);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_result !== hold || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d valid=%b result=%0d ready=%b expected 1 %0d 0",
                 i, resp_valid, resp_result, req_ready, hold);
      end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || sbq.size() != 0 || acc !== 32'd2100) begin
      errors++;
      $display("FAIL bp_release: busy=%b valid=%b outstanding=%0d acc=%0d expected 0 0 0 2100",
               busy, resp_valid, sbq.size(), acc);
    end
  endtask

  task automatic test_reset_mid;
    req_cmd = CMD_ADD; req_a = 16'd2; req_b = 16'd3; req_use_acc = 1'b0;
    resp_ready = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_settle: busy=%b expected 1", busy);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_result !== '0 || alu_a !== '0 || alu_b !== '0 || alu_cmd !== '0 ||
        acc !== '0 || sticky_err !== '0 || op_count !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: valid=%b result=%h alu=%h/%h/%h acc=%h sticky=%b count=%0d busy=%b expected all 0",
               resp_valid, resp_result, alu_a, alu_b, alu_cmd, acc, sticky_err, op_count, busy);
    end
    sbq.delete();
    m_acc = '0; m_sticky = '0; m_cnt = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_noresp: resp_valid=%b expected 0 at cycle %0d", resp_valid, i);
      end
    end
    run_op(CMD_SUB, 16'd100, 16'd30, 1'b0, S + 1);
    checks++;
    if (op_count !== 16'd1 || acc !== 32'd70) begin
      errors++;
      $display("FAIL rst_mid_after: count=%0d acc=%0d expected 1 70", op_count, acc);
    end
  endtask

  initial begin
    test_reset();
    test_cmds();
    test_overflow();
    test_screen();
    test_set_wins();
    test_chain();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
